// File: rtl/npu_queue_unit.sv
// CPU<->NPU queue block: config, input and output FWFT FIFOs plus stall flags.
// Optional sticky overflow/underflow register enabled by NPU_QUEUE_ERR_EN.
module npu_queue_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          iClk,
  input  logic          iReset,
  input  logic          iFlush,
  input  logic          iPush,
  input  logic [DW-1:0] iPushData,
  input  logic          iPop,
  output logic [DW-1:0] oHeadData,
  output logic          oFull,
  output logic          oEmpty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          pushOk;
  logic          popOk;

  // Flags come only from the registered count.
  assign oFull  = (count == FULL_COUNT);
  assign oEmpty = (count == '0);
  assign pushOk = iPush & ~oFull;
  assign popOk  = iPop & ~oEmpty;
  assign oHeadData = mem[rdPtr];

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (iFlush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      if (pushOk && !popOk)
        count <= count + 1'b1;
      else if (popOk && !pushOk)
        count <= count - 1'b1;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge iClk) begin
    if (pushOk && !iFlush) mem[wrPtr] <= iPushData;
  end
endmodule

module npu_queue_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CFG_DEPTH  = 8,
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iFlush,
  input  logic                  iCpuCfgWrite,
  input  logic                  iCpuEnqWrite,
  input  logic [DATA_WIDTH-1:0] iCpuData,
  input  logic                  iCpuDeqRead,
  output logic [DATA_WIDTH-1:0] oCpuDeqData,
  output logic                  oNpuConfigFull,
  output logic                  oNpuInputFull,
  output logic                  oNpuOutputEmpty,
  input  logic                  iNpuCfgRead,
  output logic                  oNpuCfgValid,
  output logic [DATA_WIDTH-1:0] oNpuCfgData,
  input  logic                  iNpuInRead,
  output logic                  oNpuInValid,
  output logic [DATA_WIDTH-1:0] oNpuInData,
  input  logic                  iNpuOutWrite,
  input  logic [DATA_WIDTH-1:0] iNpuOutData,
`ifdef NPU_QUEUE_ERR_EN
  output logic                  oNpuOutReady,
  output logic [5:0]            oQueueErr
`else
  output logic                  oNpuOutReady
`endif
);
  logic cfgFull;
  logic cfgEmpty;
  logic inFull;
  logic inEmpty;
  logic outFull;
  logic outEmpty;
  logic enqPush;

  // Config write owns the shared bus when both CPU strobes collide.
  assign enqPush = iCpuEnqWrite & ~iCpuCfgWrite;

  npu_queue_fifo #(
    .DW(DATA_WIDTH),
    .DEPTH(CFG_DEPTH)
  ) cfgQ (
    .iClk(iClk),
    .iReset(iReset),
    .iFlush(iFlush),
    .iPush(iCpuCfgWrite),
    .iPushData(iCpuData),
    .iPop(iNpuCfgRead),
    .oHeadData(oNpuCfgData),
    .oFull(cfgFull),
    .oEmpty(cfgEmpty)
  );

  npu_queue_fifo #(
    .DW(DATA_WIDTH),
    .DEPTH(IN_DEPTH)
  ) inQ (
    .iClk(iClk),
    .iReset(iReset),
    .iFlush(iFlush),
    .iPush(enqPush),
    .iPushData(iCpuData),
    .iPop(iNpuInRead),
    .oHeadData(oNpuInData),
    .oFull(inFull),
    .oEmpty(inEmpty)
  );

  npu_queue_fifo #(
    .DW(DATA_WIDTH),
    .DEPTH(OUT_DEPTH)
  ) outQ (
    .iClk(iClk),
    .iReset(iReset),
    .iFlush(iFlush),
    .iPush(iNpuOutWrite),
    .iPushData(iNpuOutData),
    .iPop(iCpuDeqRead),
    .oHeadData(oCpuDeqData),
    .oFull(outFull),
    .oEmpty(outEmpty)
  );

  assign oNpuConfigFull  = cfgFull;
  assign oNpuCfgValid    = ~cfgEmpty;
  assign oNpuInputFull   = inFull;
  assign oNpuInValid     = ~inEmpty;
  assign oNpuOutputEmpty = outEmpty;
  assign oNpuOutReady    = ~outFull;

`ifdef NPU_QUEUE_ERR_EN
  logic [5:0] errEvent;

  assign errEvent = {
    iCpuDeqRead & outEmpty,
    iNpuInRead & inEmpty,
    iNpuCfgRead & cfgEmpty,
    iNpuOutWrite & outFull,
    enqPush & inFull,
    iCpuCfgWrite & cfgFull
  };

  // Sticky error bits; only reset or flush clears them.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)
      oQueueErr <= '0;
    else if (iFlush)
      oQueueErr <= '0;
    else
      oQueueErr <= oQueueErr | errEvent;
  end
`endif
endmodule

// File: doc/npu_queue_unit.md
Name: npu_queue_unit

Overview:
- Upstream neighbour of the pipeline hazard detection logic: owns the three CPU↔NPU queues (config, input, output).
- Produces the `oNpuConfigFull`, `oNpuInputFull` and `oNpuOutputEmpty` flags that the stall logic consumes.
- CPU side is driven from the EX-stage NPU cfg/enq/deq ops. NPU side is a simple valid/read and write/ready interface.
- Each queue is a first-word-fall-through (FWFT) synchronous FIFO with registered pointers and occupancy counters.

Parameters:
- DATA_WIDTH, 32, width of every queue entry.
- CFG_DEPTH, 8, config queue entries; power of 2, ≥2.
- IN_DEPTH, 16, input queue entries; power of 2, ≥2.
- OUT_DEPTH, 16, output queue entries; power of 2, ≥2.

Ports:
- iClk  input  1  clock, rising edge.
- iReset  input  1  asynchronous, active-high reset.
- iFlush  input  1  synchronous clear of all three queues.
- iCpuCfgWrite  input  1  push `iCpuData` into config queue.
- iCpuEnqWrite  input  1  push `iCpuData` into input queue.
- iCpuData  input  DATA_WIDTH  CPU write data, shared by cfg/enq.
- iCpuDeqRead  input  1  pop output queue.
- oCpuDeqData  output  DATA_WIDTH  head of output queue (FWFT).
- oNpuConfigFull  output  1  config queue full.
- oNpuInputFull  output  1  input queue full.
- oNpuOutputEmpty  output  1  output queue empty.
- iNpuCfgRead  input  1  NPU pops config queue.
- oNpuCfgValid  output  1  config queue non-empty.
- oNpuCfgData  output  DATA_WIDTH  head of config queue.
- iNpuInRead  input  1  NPU pops input queue.
- oNpuInValid  output  1  input queue non-empty.
- oNpuInData  output  DATA_WIDTH  head of input queue.
- iNpuOutWrite  input  1  NPU pushes `iNpuOutData`.
- iNpuOutData  input  DATA_WIDTH  NPU result data.
- oNpuOutReady  output  1  output queue not full.

Behaviour:

Per-queue state:
- Write pointer and read pointer, each log2(DEPTH) bits.
- Count register, log2(DEPTH)+1 bits.
- Storage array; storage is not reset.

Reset (`iReset`=1, asynchronous):
- All pointers and counts go to 0.
- Therefore `oNpuConfigFull`=0, `oNpuInputFull`=0, `oNpuOutputEmpty`=1, `oNpuCfgValid`=0, `oNpuInValid`=0, `oNpuOutReady`=1.
- Data outputs are don't-care while the queue is empty.
- Reset asserted mid-operation discards all contents immediately. No partial state survives.

Flags and data outputs:
- full = (count == DEPTH); empty = (count == 0). Both are decoded from registered count only, never from same-cycle inputs.
- Data outputs = storage[rd_ptr], combinational from registered state. Head data is visible in the same cycle that valid is high.

Push:
- Accepted iff write strobe is high and full is low at the clock edge.
- Stores the data at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- A push to a full queue is dropped silently. Pointers, count and contents are unchanged.

Pop:
- Accepted iff read strobe is high and empty is low.
- rd_ptr increments modulo DEPTH.
- A pop of an empty queue is ignored.

Simultaneous push and pop in one cycle:
- Each is qualified independently against the start-of-cycle flags.
  - Both accepted: count unchanged, both pointers advance.
  - Full queue: pop accepted, push dropped, count = DEPTH-1.
  - Empty queue: push accepted, pop ignored, count = 1.
- A pushed entry becomes visible at the head on the following cycle. There is no same-cycle bypass.

Shared CPU data bus:
- `iCpuCfgWrite` and `iCpuEnqWrite` both high in one cycle: the config push takes priority and the enq push is dropped.
- Only one NPU op is in EX per cycle, so this case is a protocol error and is tolerated, not supported.

Flush (`iFlush`):
- Synchronous. On the next edge all pointers and counts of all three queues return to 0.
- Overrides every push and pop in the same cycle.

Latency:
- Push to NPU-visible valid: 1 cycle.
- Pop to flag update: 1 cycle.

Optional Feature:
- Macro: `NPU_QUEUE_ERR_EN`.
- When defined, add output `oQueueErr` [5:0], sticky, one bit per event:
  - bit0 config overflow, bit1 input overflow, bit2 output overflow.
  - bit3 config underflow, bit4 input underflow, bit5 output underflow.
- Overflow = push strobe while full (not counting the cfg/enq collision drop). Underflow = pop strobe while empty.
- Each bit sets on the edge after the event. Bits clear only on `iReset` or `iFlush`.
- When not defined: the port and its logic are absent; drops and ignores remain silent.

Test Plan:
1. Reset, then push 8 config words 0x100..0x107 with no reads → `oNpuConfigFull`=1 after the 8th edge. A 9th push of 0x1FF is dropped. NPU reads return 0x100..0x107 in order, `oNpuCfgValid` falls after the 8th pop.
2. Input queue, 40 enq/read cycles with occupancy held between 1 and 16 → pointer wraps twice, data order preserved, `oNpuInputFull` asserts exactly at count 16.
3. Output queue empty, `iNpuOutWrite` and `iCpuDeqRead` in the same cycle with data 0xABCD → pop ignored. Next cycle `oNpuOutputEmpty`=0 and `oCpuDeqData`=0xABCD.
4. Output queue full (16 entries), simultaneous push of 0x55 and pop → count = 15, 0x55 absent, `oNpuOutReady`=1.
5. Queues partly filled (3/5/7 entries), assert `iFlush` together with pushes on all queues → all counts 0 next cycle, empty/full flags at reset values. Repeat with `iReset` asserted mid-cycle → flags change before the next clock edge.
6. With `NPU_QUEUE_ERR_EN`: pop empty config queue, then push full input queue → `oQueueErr`=6'b001010, held until `iFlush`, then 0.
